// File: rtl/sim_uart_pkg.sv
// Shared types and helpers for the simulation-harness UART receiver.
package sim_uart_pkg;

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clocks per bit, truncated.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sim_uart_fifo.sv
// Byte queue behind the receiver: registered read head, no fall-through.
module sim_uart_fifo
  import sim_uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB separates full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/sim_uart_rx.sv
// Asynchronous-serial receiver: synchronizer, mid-bit sampling deserializer, byte FIFO.
//
// state       | meaning
// S_WAIT_IDLE | wait for the line to be high before looking for a start edge
// S_IDLE      | line idle, waiting for a falling edge
// S_START     | count to mid start bit, reject false starts
// S_DATA      | sample DATA_BITS data bits, LSB first
// S_PARITY    | sample the parity bit
// S_STOP      | sample stop bit, then push or flag one error
module sim_uart_rx
  import sim_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  input  logic       rx_rd,
  output logic       err_frame,
  output logic       err_parity,
  output logic       err_overrun
);

  localparam int              DIV       = calc_div(CLK_FREQ, BAUD);
  localparam int              CW        = $clog2(DIV);
  localparam logic [CW-1:0]   LOAD_HALF = CW'(DIV/2 - 1);
  localparam logic [CW-1:0]   LOAD_FULL = CW'(DIV - 1);
  localparam logic [2:0]      LAST_IDX  = 3'(DATA_BITS - 1);
  localparam bit              HAS_PAR   = (PARITY != PAR_NONE);

  rx_state_t     state;
  rx_state_t     state_nx;
  logic          rx_meta;
  logic          rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          tc;
  logic          par_ok;
  logic          stop_smp;
  logic          push;
  logic          frame_d;
  logic          parity_d;
  logic          overrun_d;
  logic          fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign tc = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_WAIT_IDLE: if (rxs) state_nx = S_IDLE;
      S_IDLE:      if (!rxs) state_nx = S_START;
      S_START:     if (tc) state_nx = rxs ? S_IDLE : S_DATA;
      S_DATA:      if (tc && idx == LAST_IDX) state_nx = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY:    if (tc) state_nx = S_STOP;
      S_STOP:      if (tc) state_nx = rxs ? S_IDLE : S_WAIT_IDLE;
      default:     state_nx = S_WAIT_IDLE;
    endcase
  end

  // Bits above DATA_BITS stay zero, so the XOR over the whole register is exact.
  always_comb begin
    par_ok = 1'b1;
    if (PARITY == PAR_ODD)       par_ok = (^shreg) ^ par_bit;
    else if (PARITY == PAR_EVEN) par_ok = ~((^shreg) ^ par_bit);
  end

  // One outcome per frame, priority frame > parity > overrun.
  always_comb begin
    stop_smp  = (state == S_STOP) && tc;
    frame_d   = stop_smp && !rxs;
    parity_d  = stop_smp && rxs && !par_ok;
    overrun_d = stop_smp && rxs && par_ok && fifo_full && !rx_rd;
    push      = stop_smp && rxs && par_ok && (!fifo_full || rx_rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (!rxs) cnt <= LOAD_HALF;
        S_START: begin
          if (tc) begin
            cnt   <= LOAD_FULL;
            idx   <= '0;
            shreg <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DATA: begin
          if (tc) begin
            shreg[idx] <= rxs;
            cnt        <= LOAD_FULL;
            if (idx != LAST_IDX) idx <= idx + 3'd1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_PARITY: begin
          if (tc) begin
            par_bit <= rxs;
            cnt     <= LOAD_FULL;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_STOP: if (!tc) cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_frame   <= frame_d;
      err_parity  <= parity_d;
      err_overrun <= overrun_d;
    end
  end

  sim_uart_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (rx_rd),
    .wdata (shreg),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (rx_empty)
  );

endmodule

// File: tb/tb_sim_uart_rx.sv
// Randomized bench for sim_uart_rx: an 8N1 instance and an 8E1 instance, checked against a frame-level model.
module tb_sim_uart_rx;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic       rd0 = 1'b0, rd1 = 1'b0;
  logic [7:0] data0, data1;
  logic       empty0, empty1;
  logic       fe0, pe0, oe0, fe1, pe1, oe1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_fall   = 0;
  int fall_cyc0 = 0;
  logic prev_empty0 = 1'b1;
  int cnt_fe[2], cnt_pe[2], cnt_oe[2];
  int exp_fe[2], exp_pe[2], exp_oe[2];
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sim_uart_rx #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .rx_data(data0), .rx_empty(empty0), .rx_rd(rd0),
    .err_frame(fe0), .err_parity(pe0), .err_overrun(oe0));

  sim_uart_rx #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)) u_dut_par (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .rx_data(data1), .rx_empty(empty1), .rx_rd(rd1),
    .err_frame(fe1), .err_parity(pe1), .err_overrun(oe1));

  // Count high cycles of each error output; a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (fe0 === 1'b1) cnt_fe[0]++;
    if (pe0 === 1'b1) cnt_pe[0]++;
    if (oe0 === 1'b1) cnt_oe[0]++;
    if (fe1 === 1'b1) cnt_fe[1]++;
    if (pe1 === 1'b1) cnt_pe[1]++;
    if (oe1 === 1'b1) cnt_oe[1]++;
    if (prev_empty0 && !empty0) fall_cyc0 = cyc;
    prev_empty0 = empty0;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int sel, input logic b);
    if (sel == 0) rx0 = b;
    else          rx1 = b;
  endtask

  task automatic set_rd(input int sel, input logic b);
    if (sel == 0) rd0 = b;
    else          rd1 = b;
  endtask

  task automatic drive_bit(input int sel, input logic b);
    @(posedge clk); #1;
    set_rx(sel, b);
    repeat (DIV-1) @(posedge clk);
  endtask

  task automatic idle(input int sel, input int n);
    @(posedge clk); #1;
    set_rx(sel, 1'b1);
    repeat (n-1) @(posedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input int pmode,
                            input logic pbit, input logic stop);
    @(posedge clk); #1;
    set_rx(sel, 1'b0);
    t_fall = cyc;
    repeat (DIV-1) @(posedge clk);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (pmode != 0) drive_bit(sel, pbit);
    drive_bit(sel, stop);
  endtask

  // Frame-level reference: decide the single outcome of a frame from its bits.
  task automatic model_frame(input int sel, input logic [7:0] d, input int pmode,
                             input logic pbit, input logic stop, input bit popping);
    int ones;
    bit par_good;
    int depth;
    ones     = $countones(d) + int'(pbit);
    par_good = (pmode == 0) || (pmode == 1 && ones % 2 == 1) || (pmode == 2 && ones % 2 == 0);
    depth    = (sel == 0) ? q0.size() : q1.size();
    if (!stop)                      exp_fe[sel]++;
    else if (!par_good)             exp_pe[sel]++;
    else if (depth == 4 && !popping) exp_oe[sel]++;
    else if (sel == 0) begin
      if (popping) void'(q0.pop_front());
      q0.push_back(d);
    end else begin
      if (popping) void'(q1.pop_front());
      q1.push_back(d);
    end
  endtask

  task automatic check_state(input int sel, input string tag);
    logic e;
    int   qs;
    @(negedge clk);
    e  = (sel == 0) ? empty0 : empty1;
    qs = (sel == 0) ? q0.size() : q1.size();
    check_val({tag, " err_frame count"},   cnt_fe[sel], exp_fe[sel]);
    check_val({tag, " err_parity count"},  cnt_pe[sel], exp_pe[sel]);
    check_val({tag, " err_overrun count"}, cnt_oe[sel], exp_oe[sel]);
    check_val({tag, " rx_empty"}, e, (qs == 0));
  endtask

  task automatic run_frame(input int sel, input logic [7:0] d, input int pmode,
                           input logic pbit, input logic stop, input string tag);
    send_frame(sel, d, pmode, pbit, stop);
    model_frame(sel, d, pmode, pbit, stop, 1'b0);
    check_state(sel, tag);
  endtask

  task automatic pop_check(input int sel, input string tag);
    logic [7:0] e;
    @(negedge clk);
    if (sel == 0) begin
      if (q0.size() == 0) begin
        check_val({tag, " empty"}, empty0, 1);
        return;
      end
      e = q0.pop_front();
      check_val({tag, " not empty"}, empty0, 0);
      check_val({tag, " data"}, data0, e);
    end else begin
      if (q1.size() == 0) begin
        check_val({tag, " empty"}, empty1, 1);
        return;
      end
      e = q1.pop_front();
      check_val({tag, " not empty"}, empty1, 0);
      check_val({tag, " data"}, data1, e);
    end
    @(posedge clk); #1;
    set_rd(sel, 1'b1);
    @(posedge clk); #1;
    set_rd(sel, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    logic       pb;
    logic       st;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset rx_empty", empty0, 1);
    check_val("reset rx_data", data0, 0);
    check_val("reset err_frame", fe0, 0);
    check_val("reset err_parity", pe0, 0);
    check_val("reset err_overrun", oe0, 0);
    check_val("reset par rx_empty", empty1, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    // 0x55 8N1 with exact push latency
    send_frame(0, 8'h55, 0, 1'b0, 1'b1);
    model_frame(0, 8'h55, 0, 1'b0, 1'b1, 1'b0);
    check_val("t1 empty fall cycle", fall_cyc0, t_fall + 2 + DIV/2 + 9*DIV + 1);
    check_state(0, "t1");
    pop_check(0, "t1 pop");
    pop_check(0, "t1 drained");

    // 4-cycle glitch is a false start
    @(posedge clk); #1;
    rx0 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx0 = 1'b1;
    repeat (30) @(posedge clk);
    check_state(0, "t2 glitch");

    // framing error, then clean byte
    run_frame(0, 8'hA3, 0, 1'b0, 1'b0, "t3 bad stop");
    idle(0, 20);
    run_frame(0, 8'h3C, 0, 1'b0, 1'b1, "t3 after");
    pop_check(0, "t3 pop");

    // even parity
    run_frame(1, 8'h07, 2, 1'b0, 1'b1, "t4 bad parity");
    idle(1, 20);
    run_frame(1, 8'h07, 2, 1'b1, 1'b1, "t4 good parity");
    pop_check(1, "t4 pop");

    // overrun on the fifth back-to-back byte
    for (int b = 1; b <= 5; b++) run_frame(0, 8'(b), 0, 1'b0, 1'b1, "t5 fill");
    for (int b = 0; b < 5; b++) pop_check(0, "t5 pop");

    // pop coinciding with the fifth push: no overrun
    for (int b = 1; b <= 4; b++) run_frame(0, 8'(b), 0, 1'b0, 1'b1, "t5b fill");
    fork
      send_frame(0, 8'h05, 0, 1'b0, 1'b1);
      begin
        @(posedge clk); #2;
        repeat (154) @(posedge clk);
        #1 rd0 = 1'b1;
        @(posedge clk);
        #1 rd0 = 1'b0;
      end
    join
    model_frame(0, 8'h05, 0, 1'b0, 1'b1, 1'b1);
    check_state(0, "t5b concurrent pop");
    for (int b = 0; b < 5; b++) pop_check(0, "t5b pop");

    // randomized frames with random errors and pops
    for (int sel = 0; sel < 2; sel++) begin
      for (int n = 0; n < 20; n++) begin
        d  = 8'($urandom);
        st = ($urandom_range(0, 7) != 0);
        pb = (^d) ^ ($urandom_range(0, 3) == 0);
        run_frame(sel, d, (sel == 0) ? 0 : 2, pb, st, "rnd frame");
        if (!st || $urandom_range(0, 1) == 1) idle(sel, $urandom_range(3, 12));
        repeat ($urandom_range(0, 2)) pop_check(sel, "rnd pop");
      end
      repeat (5) pop_check(sel, "rnd drain");
    end

    // reset in the middle of a low byte, released while the line is still low
    @(posedge clk); #1;
    rx0 = 1'b0;
    repeat (3*DIV) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("t6 reset rx_empty", empty0, 1);
    check_val("t6 reset rx_data", data0, 0);
    check_val("t6 reset err_frame", fe0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rx0 = 1'b1;
    repeat (200) @(posedge clk);
    check_state(0, "t6 after release");
    run_frame(0, 8'hFF, 0, 1'b0, 1'b1, "t6 0xFF");
    pop_check(0, "t6 pop");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
